// File: rtl/bm_pkg.sv
// Shared types and sizing helpers for the batch-norm gradient collector.
package bm_pkg;

  // Collector phases: gather both input streams, then drain them downstream.
  typedef enum logic {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_t;

  // clog2 that never returns 0, so a pointer is always at least one bit wide.
  function automatic int clog2_min1(input int value);
    return (value < 2) ? 1 : $clog2(value);
  endfunction

  // Widths for the default configuration (hidden_num = 16). Modules derive
  // their own widths from their actual hidden_num with clog2_min1.
  localparam int HIDDEN_NUM_DEFAULT = 16;
  localparam int PTR_W              = clog2_min1(HIDDEN_NUM_DEFAULT);
  localparam int OUT_CNT_W          = clog2_min1(2 * HIDDEN_NUM_DEFAULT);

endpackage

// File: rtl/bm_grad_capture.sv
// One input stream's frame buffer: storage, write pointer, done flag and
// length/overflow event detection. Read port is combinational so a word
// written on the final input cycle is visible on the very next cycle.
module bm_grad_capture
  import bm_pkg::*;
#(
  parameter int bitwidth   = 16,
  parameter int hidden_num = 16,
  localparam int ptr_w     = clog2_min1(hidden_num)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clr,
  input  logic                collect,
  input  logic [bitwidth-1:0] in_data,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic [ptr_w-1:0]    rd_idx,
  output logic [bitwidth-1:0] rd_data,
  output logic                done_next,
  output logic                len_evt,
  output logic                ovf_evt
);

  logic [bitwidth-1:0]   mem [hidden_num];
  logic [hidden_num-1:0] vld_reg;
  logic [ptr_w-1:0]      ptr_reg;
  logic                  done_reg;
  logic                  accept;
  logic                  at_end;

  assign accept    = in_valid && collect && !done_reg;
  assign at_end    = (ptr_reg == ptr_w'(hidden_num - 1));
  // Frame closes on an explicit last or when the buffer fills without one.
  assign done_next = !clr && (done_reg || (accept && (in_last || at_end)));
  // Length error: last too early, or buffer full with no last.
  assign len_evt   = accept && (in_last ? !at_end : at_end);
  // Any word that is not accepted is lost (frame closed or draining).
  assign ovf_evt   = in_valid && !accept;
  // Entries never written in this frame read back as zero.
  assign rd_data   = vld_reg[rd_idx] ? mem[rd_idx] : '0;

  // Pointer and done flag: advance per accepted word, cleared after a drain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_reg  <= '0;
      done_reg <= 1'b0;
    end else if (clr) begin
      ptr_reg  <= '0;
      done_reg <= 1'b0;
    end else if (accept) begin
      done_reg <= done_next;
      if (!(in_last || at_end)) begin
        ptr_reg <= ptr_reg + ptr_w'(1);
      end
    end
  end

  // Per-entry valid bits: set on write, wiped together when the frame drains.
  for (genvar gi = 0; gi < hidden_num; gi++) begin : g_vld
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        vld_reg[gi] <= 1'b0;
      end else if (clr) begin
        vld_reg[gi] <= 1'b0;
      end else if (accept && (ptr_reg == ptr_w'(gi))) begin
        vld_reg[gi] <= 1'b1;
      end
    end
  end

  // Data storage: no reset needed, the valid bits qualify every read.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[ptr_reg] <= in_data;
    end
  end

endmodule

// File: rtl/bm_grad_collector.sv
// Collects one gradg frame and one gradb frame, then emits them back to back
// as a single AXI-Stream frame (gradg first) with tready backpressure.
module bm_grad_collector
  import bm_pkg::*;
#(
  parameter int bitwidth   = 16,
  parameter int hidden_num = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [bitwidth-1:0] gradg_in,
  input  logic                gradg_in_valid,
  input  logic                gradg_in_last,
  input  logic [bitwidth-1:0] gradb_in,
  input  logic                gradb_in_valid,
  input  logic                gradb_in_last,
  output logic [bitwidth-1:0] m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                busy,
  output logic                err_overflow,
  output logic                err_len,
  input  logic                err_clr
);

  localparam int ptr_w = clog2_min1(hidden_num);
  localparam int cnt_w = clog2_min1(2 * hidden_num);

  state_t              state_reg, state_next;
  logic [cnt_w-1:0]    rd_ptr_reg, rd_ptr_next;
  logic                err_overflow_reg, err_len_reg;
  logic                collect, frame_end, at_last, rd_sel_b;
  logic [ptr_w-1:0]    rd_idx;
  logic [bitwidth-1:0] g_rd, b_rd;
  logic                g_done_next, b_done_next;
  logic                g_len_evt, b_len_evt, g_ovf_evt, b_ovf_evt;

  assign collect   = (state_reg == COLLECT);
  assign at_last   = (rd_ptr_reg == cnt_w'(2 * hidden_num - 1));
  assign frame_end = (state_reg == SEND) && m_axis_tready && at_last;
  // Upper half of the output index addresses the gradb buffer.
  assign rd_sel_b  = (rd_ptr_reg >= cnt_w'(hidden_num));
  assign rd_idx    = ptr_w'(rd_sel_b ? (rd_ptr_reg - cnt_w'(hidden_num)) : rd_ptr_reg);

  bm_grad_capture #(.bitwidth(bitwidth), .hidden_num(hidden_num)) u_cap_g (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (frame_end),
    .collect   (collect),
    .in_data   (gradg_in),
    .in_valid  (gradg_in_valid),
    .in_last   (gradg_in_last),
    .rd_idx    (rd_idx),
    .rd_data   (g_rd),
    .done_next (g_done_next),
    .len_evt   (g_len_evt),
    .ovf_evt   (g_ovf_evt)
  );

  bm_grad_capture #(.bitwidth(bitwidth), .hidden_num(hidden_num)) u_cap_b (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (frame_end),
    .collect   (collect),
    .in_data   (gradb_in),
    .in_valid  (gradb_in_valid),
    .in_last   (gradb_in_last),
    .rd_idx    (rd_idx),
    .rd_data   (b_rd),
    .done_next (b_done_next),
    .len_evt   (b_len_evt),
    .ovf_evt   (b_ovf_evt)
  );

  // FSM state and output index register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= COLLECT;
      rd_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Next state and stream outputs; outputs are pure functions of registers
  // so they stay stable while the consumer stalls.
  always_comb begin
    state_next    = state_reg;
    rd_ptr_next   = rd_ptr_reg;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    busy          = 1'b0;
    case (state_reg)
      COLLECT: begin
        // Enter SEND as the last outstanding input word is written.
        if (g_done_next && b_done_next) begin
          state_next  = SEND;
          rd_ptr_next = '0;
        end
      end
      SEND: begin
        busy          = 1'b1;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = at_last;
        m_axis_tdata  = rd_sel_b ? b_rd : g_rd;
        if (m_axis_tready) begin
          if (at_last) begin
            state_next  = COLLECT;
            rd_ptr_next = '0;
          end else begin
            rd_ptr_next = rd_ptr_reg + cnt_w'(1);
          end
        end
      end
    endcase
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_overflow_reg <= 1'b0;
      err_len_reg      <= 1'b0;
    end else begin
      err_overflow_reg <= (err_overflow_reg && !err_clr) || g_ovf_evt || b_ovf_evt;
      err_len_reg      <= (err_len_reg && !err_clr) || g_len_evt || b_len_evt;
    end
  end

  assign err_overflow = err_overflow_reg;
  assign err_len      = err_len_reg;

endmodule

// File: tb/tb_bm_grad_collector.sv
// Directed plus randomized bench for bm_grad_collector (H=4, 16-bit words).
module tb_bm_grad_collector;

  localparam int BW = 16;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [BW-1:0] gradg_in = '0, gradb_in = '0;
  logic          gradg_in_valid = 1'b0, gradg_in_last = 1'b0;
  logic          gradb_in_valid = 1'b0, gradb_in_last = 1'b0;
  logic [BW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          busy, err_overflow, err_len;
  logic          err_clr = 1'b0;

  bm_grad_collector #(.bitwidth(BW), .hidden_num(H)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .gradg_in       (gradg_in),
    .gradg_in_valid (gradg_in_valid),
    .gradg_in_last  (gradg_in_last),
    .gradb_in       (gradb_in),
    .gradb_in_valid (gradb_in_valid),
    .gradb_in_last  (gradb_in_last),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .busy           (busy),
    .err_overflow   (err_overflow),
    .err_len        (err_len),
    .err_clr        (err_clr)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int miss = 0;
  int cyc = 0;
  int pat_i = 0;
  int rdy_mode = 0;   // 0: always ready, 1: 1,0,0 pattern, 2: random

  // Observed output beats.
  logic [BW-1:0] obs_d[$];
  logic          obs_l[$];
  // Reference model: words each stream has taken into the current frame.
  logic [BW-1:0] acc_g[$];
  logic [BW-1:0] acc_b[$];
  logic [BW-1:0] exp_q[$];
  bit m_g_closed = 0, m_b_closed = 0;
  bit exp_len = 0, exp_ovf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: pick tready, log a handshake, advance, verify stall stability.
  task automatic tick();
    bit stall_prev;
    logic [BW-1:0] d_prev;
    logic l_prev;
    case (rdy_mode)
      0: m_axis_tready = 1'b1;
      1: begin m_axis_tready = (pat_i % 3 == 0); pat_i++; end
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
    if (m_axis_tvalid && m_axis_tready) begin
      obs_d.push_back(m_axis_tdata);
      obs_l.push_back(m_axis_tlast);
    end
    stall_prev = m_axis_tvalid && !m_axis_tready;
    d_prev = m_axis_tdata;
    l_prev = m_axis_tlast;
    @(posedge clk);
    #1;
    cyc++;
    if (stall_prev) chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, l_prev, d_prev});
  endtask

  // Model of one stream: a frame closes on last or after H words; anything
  // arriving on a closed stream is lost.
  task automatic model_word(input bit is_g, input logic [BW-1:0] d, input bit last);
    if (is_g ? m_g_closed : m_b_closed) begin
      exp_ovf = 1;
    end else if (is_g) begin
      acc_g.push_back(d);
      if (last || acc_g.size() == H) begin
        m_g_closed = 1;
        if (!(last && acc_g.size() == H)) exp_len = 1;
      end
    end else begin
      acc_b.push_back(d);
      if (last || acc_b.size() == H) begin
        m_b_closed = 1;
        if (!(last && acc_b.size() == H)) exp_len = 1;
      end
    end
  endtask

  task automatic put(input bit gv, input logic [BW-1:0] gd, input bit gl,
                     input bit bv, input logic [BW-1:0] bd, input bit bl);
    gradg_in_valid = gv; gradg_in = gd; gradg_in_last = gl;
    gradb_in_valid = bv; gradb_in = bd; gradb_in_last = bl;
    if (gv) model_word(1'b1, gd, gl);
    if (bv) model_word(1'b0, bd, bl);
    tick();
    gradg_in_valid = 0; gradg_in_last = 0;
    gradb_in_valid = 0; gradb_in_last = 0;
  endtask

  // Output frame: each buffer in order, unwritten slots as zero.
  task automatic make_exp();
    exp_q.delete();
    for (int k = 0; k < H; k++) exp_q.push_back(k < acc_g.size() ? acc_g[k] : '0);
    for (int k = 0; k < H; k++) exp_q.push_back(k < acc_b.size() ? acc_b[k] : '0);
  endtask

  task automatic model_clear();
    acc_g.delete(); acc_b.delete();
    m_g_closed = 0; m_b_closed = 0;
  endtask

  // Drain one frame; optionally inject a gradb word after inj_at beats.
  task automatic recv(input int inj_at);
    int budget = 0;
    bit injected = 0;
    while (obs_d.size() < 2 * H && budget < 300) begin
      if (inj_at >= 0 && !injected && obs_d.size() == inj_at) begin
        gradb_in_valid = 1; gradb_in = 16'hBEEF;
        exp_ovf = 1;
        injected = 1;
        tick();
        gradb_in_valid = 0;
      end else begin
        tick();
      end
      budget++;
    end
    chk("beat_count", obs_d.size(), 2 * H);
    for (int i = 0; i < obs_d.size() && i < exp_q.size(); i++) begin
      chk($sformatf("word%0d", i), obs_d[i], exp_q[i]);
      chk($sformatf("tlast%0d", i), obs_l[i], (i == 2 * H - 1));
    end
    chk("busy_after_frame", busy, 0);
    chk("tvalid_after_frame", m_axis_tvalid, 0);
    obs_d.delete(); obs_l.delete();
    model_clear();
  endtask

  task automatic check_errs(input string tag);
    chk({tag, "_err_len"}, err_len, exp_len);
    chk({tag, "_err_ovf"}, err_overflow, exp_ovf);
  endtask

  task automatic clear_errs();
    err_clr = 1;
    tick();
    err_clr = 0;
    exp_len = 0; exp_ovf = 0;
    check_errs("after_clr");
  endtask

  task automatic nominal_frame();
    put(1, 16'd1, 0, 0, 16'd0, 0);
    put(1, 16'd2, 0, 0, 16'd0, 0);
    put(1, 16'd3, 0, 1, 16'd5, 0);
    put(1, 16'd4, 1, 1, 16'd6, 0);
    put(0, 16'd0, 0, 1, 16'd7, 0);
    chk("tvalid_before_done", m_axis_tvalid, 0);
    put(0, 16'd0, 0, 1, 16'd8, 1);
  endtask

  initial begin
    int start, lg, lb, gi, bi, guard;
    logic [BW-1:0] gd, bd;
    bit gv, bv;

    // Reset state.
    rstn = 0;
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    check_errs("rst");
    tick(); tick();
    rstn = 1;
    tick();

    // Nominal frame, always ready: first word in the cycle after the last write.
    rdy_mode = 0;
    nominal_frame();
    chk("tvalid_rise", m_axis_tvalid, 1);
    chk("first_word", m_axis_tdata, 1);
    chk("busy_send", busy, 1);
    start = cyc;
    make_exp();
    recv(-1);
    chk("send_cycles", cyc - start, 2 * H);
    check_errs("nominal");

    // Backpressure with tready 1,0,0,...
    rdy_mode = 1; pat_i = 0;
    nominal_frame();
    make_exp();
    recv(-1);
    check_errs("backpressure");

    // Short gradg frame: last on the second word.
    rdy_mode = 0;
    put(1, 16'd9, 0, 1, 16'd5, 0);
    put(1, 16'd10, 1, 1, 16'd6, 0);
    put(0, 16'd0, 0, 1, 16'd7, 0);
    put(0, 16'd0, 0, 1, 16'd8, 1);
    make_exp();
    recv(-1);
    check_errs("short");
    clear_errs();

    // Missing last on gradg, plus a fifth gradg word while gradb is open.
    put(1, 16'd11, 0, 1, 16'd5, 0);
    put(1, 16'd12, 0, 1, 16'd6, 0);
    put(1, 16'd13, 0, 1, 16'd7, 0);
    put(1, 16'd14, 0, 0, 16'd0, 0);
    put(1, 16'd15, 0, 0, 16'd0, 0);
    chk("no_send_yet", m_axis_tvalid, 0);
    put(0, 16'd0, 0, 1, 16'd8, 1);
    make_exp();
    recv(-1);
    check_errs("missing_last");
    clear_errs();

    // Overflow injected mid-SEND; frame content must be unaffected.
    rdy_mode = 2;
    nominal_frame();
    make_exp();
    recv(3);
    check_errs("ovf_send");
    clear_errs();

    // Reset in the middle of SEND after three beats.
    rdy_mode = 0;
    nominal_frame();
    guard = 0;
    while (obs_d.size() < 3 && guard < 50) begin tick(); guard++; end
    chk("pre_reset_beats", obs_d.size(), 3);
    rstn = 0;
    #1;
    chk("midrst_tvalid", m_axis_tvalid, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1;
    rstn = 1;
    obs_d.delete(); obs_l.delete();
    model_clear();
    exp_len = 0; exp_ovf = 0;
    tick();
    put(1, 16'h21, 0, 1, 16'h31, 0);
    put(1, 16'h22, 0, 1, 16'h32, 0);
    put(1, 16'h23, 0, 1, 16'h33, 0);
    put(1, 16'h24, 1, 1, 16'h34, 1);
    make_exp();
    recv(-1);
    check_errs("after_midrst");

    // Randomized frames: random data, gaps, occasional short frames, random tready.
    rdy_mode = 2;
    for (int f = 0; f < 20; f++) begin
      lg = ($urandom_range(0, 3) == 0) ? $urandom_range(1, H) : H;
      lb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, H) : H;
      gi = 0; bi = 0; guard = 0;
      while ((gi < lg || bi < lb) && guard < 200) begin
        gv = (gi < lg) && ($urandom_range(0, 1) == 1);
        bv = (bi < lb) && ($urandom_range(0, 1) == 1);
        gd = BW'($urandom);
        bd = BW'($urandom);
        put(gv, gd, gv && (gi == lg - 1), bv, bd, bv && (bi == lb - 1));
        if (gv) gi++;
        if (bv) bi++;
        guard++;
      end
      make_exp();
      recv(-1);
      check_errs($sformatf("rand%0d", f));
      if (exp_len || exp_ovf) clear_errs();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
